// File: rtl/grey_decoder_pipe.sv
// grey_decoder_pipe: two-stage pipelined Gray-to-binary decoder with valid/ready flow control.
// Define GREY_STEP_CHECK_EN to add o_step_err, flagging accepted codes that are not a unit step from the previous one.
module grey_decoder_pipe #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_grey,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_bin,
  input  logic             i_ready
`ifdef GREY_STEP_CHECK_EN
  ,
  output logic             o_step_err
`endif
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_grey;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_bin;
  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [WIDTH-1:0] w_s1_bin;

  assign w_s2_adv = ~r_s2_valid | i_ready;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign o_ready  = i_en & w_s1_adv;
  assign o_valid  = r_s2_valid;
  assign o_bin    = r_s2_bin;

  // bin[k] is the XOR of all Gray bits at or above k.
  always_comb begin
    w_s1_bin = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      w_s1_bin[k] = ^(r_s1_grey >> k);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_grey  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= i_valid & i_en;
      r_s1_grey  <= i_grey;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_bin   <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_bin   <= w_s1_bin;
    end
  end

`ifdef GREY_STEP_CHECK_EN
  logic             r_first;
  logic [WIDTH-1:0] r_last;
  logic             r_s1_err;
  logic             r_s2_err;
  logic             w_in_xfer;
  logic             w_step_err;

  assign w_in_xfer  = i_valid & o_ready;
  // The first word after reset has no predecessor; a repeated code is not one-hot and so flags.
  assign w_step_err = ~r_first & ~$onehot(i_grey ^ r_last);
  assign o_step_err = r_s2_err & r_s2_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_first <= 1'b1;
      r_last  <= '0;
    end else if (w_in_xfer) begin
      r_first <= 1'b0;
      r_last  <= i_grey;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_err <= 1'b0;
      r_s2_err <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_err <= w_step_err;
      if (w_s2_adv) r_s2_err <= r_s1_err;
    end
  end
`endif

endmodule
